// File: rtl/tlb_op_ctrl_pkg.sv
// Shared TLB definitions: entry layout, cp0 register views, op codes and
// sequencer state encodings used by the TLB op controller and its helpers.
package tlb_op_ctrl_pkg;

  localparam int NR_TLB_ENTRY = 32;

  typedef enum logic [1:0] {
    TLBP  = 2'd0,
    TLBR  = 2'd1,
    TLBWI = 2'd2,
    TLBWR = 2'd3
  } tlb_op_t;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [4:0]  zero;
    logic [7:0]  asid;
  } cp0_entryhi_t;

  typedef struct packed {
    logic [5:0]  fill;
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        d;
    logic        v;
    logic        g;
  } cp0_entrylo_t;

  typedef struct packed {
    logic                              p;
    logic [30-$clog2(NR_TLB_ENTRY):0]  zero;
    logic [$clog2(NR_TLB_ENTRY)-1:0]   index;
  } cp0_index_t;

  // One L2 TLB entry; a single G bit covers both halves of the pair.
  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  typedef logic [2:0] tlb_ctrl_state_t;

  localparam tlb_ctrl_state_t S_IDLE      = 3'd0;
  localparam tlb_ctrl_state_t S_PROBE     = 3'd1;
  localparam tlb_ctrl_state_t S_PROBE_FIN = 3'd2;
  localparam tlb_ctrl_state_t S_READ      = 3'd3;
  localparam tlb_ctrl_state_t S_READ_FIN  = 3'd4;
  localparam tlb_ctrl_state_t S_WRITE     = 3'd5;
  localparam tlb_ctrl_state_t S_FENCE     = 3'd6;
  localparam tlb_ctrl_state_t S_DONE      = 3'd7;

endpackage

// File: rtl/tlb_probe_cmp.sv
// Combinational TLBP matcher for one group of entries: reports whether any
// way matches EntryHi and which way is the lowest-numbered match.
module tlb_probe_cmp
  import tlb_op_ctrl_pkg::*;
#(
  parameter int WAYS = 4,
  localparam int WW = $clog2(WAYS)
) (
  input  tlb_entry_t [WAYS-1:0] entries,
  input  logic [18:0]           vpn2,
  input  logic [7:0]            asid,
  output logic                  hit,
  output logic [WW-1:0]         way
);

  logic [WAYS-1:0] match;
  logic            unused_fields;

  // Only VPN2/ASID/G take part in matching; the PFN halves are don't-care here.
  assign unused_fields = ^entries;

  // A way matches on equal VPN2 and either a global entry or an equal ASID.
  always_comb begin
    match = '0;
    for (int w = 0; w < WAYS; w++) begin
      match[w] = (entries[w].vpn2 == vpn2) && (entries[w].g || (entries[w].asid == asid));
    end
  end

  // Scan from the top way down so the lowest matching way is the one left.
  always_comb begin
    hit = |match;
    way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (match[w]) way = WW'(w);
    end
  end

endmodule

// File: rtl/tlb_op_ctrl.sv
// Multi-cycle sequencer for TLBP/TLBR/TLBWI/TLBWR. Accepts one op from the
// M stage, walks the L2 TLB array, returns Index/EntryHi/EntryLo updates to
// cp0, and fences the L1 micro-TLBs after every write.
module tlb_op_ctrl
  import tlb_op_ctrl_pkg::*;
#(
  parameter int NR_TLB_ENTRY = tlb_op_ctrl_pkg::NR_TLB_ENTRY,
  parameter int PROBE_WAYS   = 4,
  localparam int IW = $clog2(NR_TLB_ENTRY),
  localparam int GW = $clog2(NR_TLB_ENTRY / PROBE_WAYS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        op_valid,
  input  tlb_op_t                     op,
  output logic                        op_ready,
  output logic                        stall,
  output logic                        done,
  input  logic [IW-1:0]               cp0_index,
  input  logic [IW-1:0]               cp0_random,
  input  logic [31:0]                 cp0_entryhi,
  input  logic [31:0]                 cp0_entrylo0,
  input  logic [31:0]                 cp0_entrylo1,
  output logic [GW-1:0]               tlb_rd_grp,
  output logic                        tlb_rd_en,
  input  tlb_entry_t [PROBE_WAYS-1:0] tlb_rd_data,
  output logic                        tlb_we,
  output logic [IW-1:0]               tlb_waddr,
  output tlb_entry_t                  tlb_wdata,
  output logic                        index_we,
  output logic [31:0]                 index_wdata,
  output logic                        tlbr_we,
  output logic [31:0]                 entryhi_wdata,
  output logic [31:0]                 entrylo0_wdata,
  output logic [31:0]                 entrylo1_wdata,
  output logic                        fence_req,
  input  logic                        fence_ack
);

  localparam int WW = $clog2(PROBE_WAYS);
  localparam logic [GW-1:0] LAST_GRP = GW'((NR_TLB_ENTRY / PROBE_WAYS) - 1);

  tlb_ctrl_state_t state;
  tlb_op_t         op_q;
  tlb_entry_t      wr_entry_q;
  tlb_entry_t      rd_entry_q;
  logic [IW-1:0]   idx_q;
  logic [GW-1:0]   grp_cnt;
  logic [GW-1:0]   cmp_grp;
  logic            cmp_valid;
  logic            hit_found;
  logic [IW-1:0]   hit_idx;
  logic            probe_hit;
  logic [WW-1:0]   probe_way;

  cp0_entryhi_t    ehi_in;
  cp0_entrylo_t    lo0_in;
  cp0_entrylo_t    lo1_in;
  logic            unused_bits;

  assign ehi_in      = cp0_entryhi;
  assign lo0_in      = cp0_entrylo0;
  assign lo1_in      = cp0_entrylo1;
  assign unused_bits = ^{ehi_in.zero, lo0_in.fill, lo1_in.fill};

  tlb_probe_cmp #(.WAYS(PROBE_WAYS)) u_probe_cmp (
    .entries (tlb_rd_data),
    .vpn2    (wr_entry_q.vpn2),
    .asid    (wr_entry_q.asid),
    .hit     (probe_hit),
    .way     (probe_way)
  );

  // Sequencer: latch the op and its operands at accept, then step through the op.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      op_q       <= TLBP;
      wr_entry_q <= '0;
      rd_entry_q <= '0;
      idx_q      <= '0;
      grp_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (op_valid) begin
            op_q       <= op;
            idx_q      <= (op == TLBWR) ? cp0_random : cp0_index;
            grp_cnt    <= '0;
            wr_entry_q <= '{vpn2: ehi_in.vpn2, asid: ehi_in.asid, g: lo0_in.g & lo1_in.g,
                            pfn0: lo0_in.pfn, c0: lo0_in.c, d0: lo0_in.d, v0: lo0_in.v,
                            pfn1: lo1_in.pfn, c1: lo1_in.c, d1: lo1_in.d, v1: lo1_in.v};
            case (op)
              TLBP:    state <= S_PROBE;
              TLBR:    state <= S_READ;
              default: state <= S_WRITE;
            endcase
          end
        end
        S_PROBE: begin
          if (grp_cnt == LAST_GRP) state <= S_PROBE_FIN;
          else                     grp_cnt <= grp_cnt + 1'b1;
        end
        S_PROBE_FIN: state <= S_DONE;
        S_READ:      state <= S_READ_FIN;
        S_READ_FIN: begin
          rd_entry_q <= tlb_rd_data[idx_q[WW-1:0]];
          state      <= S_DONE;
        end
        S_WRITE: state <= S_FENCE;
        S_FENCE: if (fence_ack) state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Probe accumulator: groups arrive in ascending order, so the first hit seen is the lowest index.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_valid <= 1'b0;
      cmp_grp   <= '0;
      hit_found <= 1'b0;
      hit_idx   <= '0;
    end else begin
      cmp_valid <= (state == S_PROBE);
      cmp_grp   <= grp_cnt;
      if (state == S_IDLE) begin
        hit_found <= 1'b0;
        hit_idx   <= '0;
      end else if (cmp_valid && probe_hit && !hit_found) begin
        hit_found <= 1'b1;
        hit_idx   <= {cmp_grp, probe_way};
      end
    end
  end

  // Outputs decode from state; data buses are zero whenever their strobe is low.
  always_comb begin
    op_ready       = (state == S_IDLE);
    done           = (state == S_DONE);
    index_we       = done && (op_q == TLBP);
    tlbr_we        = done && (op_q == TLBR);
    tlb_rd_en      = (state == S_PROBE) || (state == S_READ);
    tlb_rd_grp     = '0;
    if (state == S_PROBE)     tlb_rd_grp = grp_cnt;
    else if (state == S_READ) tlb_rd_grp = idx_q[IW-1:WW];
    tlb_we         = (state == S_WRITE);
    tlb_waddr      = tlb_we ? idx_q : '0;
    tlb_wdata      = tlb_we ? wr_entry_q : '0;
    fence_req      = (state == S_FENCE);
    index_wdata    = '0;
    if (index_we) index_wdata = {~hit_found, {(31-IW){1'b0}}, hit_idx};
    entryhi_wdata  = '0;
    entrylo0_wdata = '0;
    entrylo1_wdata = '0;
    if (tlbr_we) begin
      entryhi_wdata  = {rd_entry_q.vpn2, 5'b0, rd_entry_q.asid};
      entrylo0_wdata = {6'b0, rd_entry_q.pfn0, rd_entry_q.c0, rd_entry_q.d0, rd_entry_q.v0, rd_entry_q.g};
      entrylo1_wdata = {6'b0, rd_entry_q.pfn1, rd_entry_q.c1, rd_entry_q.d1, rd_entry_q.v1, rd_entry_q.g};
    end
  end

  assign stall = op_valid & ~done;

endmodule
